// File: rtl/async_fifo_rd_arbiter.sv
// async_fifo_rd_arbiter: round-robin burst drain of NUM_CH FIFO read ports into one channel-tagged valid/ready stream
module async_fifo_rd_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         rclk,
    input  logic                         rrst_n,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH-1:0]            fifo_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_rdata,
    output logic [NUM_CH-1:0]            fifo_rd_en,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nxt;
    logic [CH_W-1:0] grant, rr_last, pick, pend_ch;
    logic [NUM_CH-1:0] cand;
    logic [7:0] burst_cnt;
    logic [1:0] count;
    logic pick_vld, issue, burst_end, credit_ok, pop, rd_pend, rd_ptr, wr_ptr;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [CH_W-1:0] buf_ch [2];

    // Scan downward so the candidate closest after rr_last is the last one written.
    always_comb begin
        int idx;
        idx = 0;
        cand = ch_enable & ~fifo_empty;
        pick = '0;
        pick_vld = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = int'(rr_last) + k;
            idx = (idx >= NUM_CH) ? idx - NUM_CH : idx;
            if (cand[idx[CH_W-1:0]]) begin
                pick = idx[CH_W-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    assign pop = out_valid & out_ready;
    // Words already in the buffer or in flight, minus the one leaving now, must leave room.
    assign credit_ok = ({1'b0, count} + {2'b0, rd_pend}) < (3'd2 + {2'b0, pop});

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        burst_end = (issue & (burst_cnt == 8'(BURST_MAX - 1))) | fifo_empty[grant] | ~ch_enable[grant];
        state_nxt = (state == IDLE) ? (pick_vld ? BURST : IDLE) : (burst_end ? IDLE : BURST);
    end

    always_comb begin
        issue = (state == BURST) & ~fifo_empty[grant] & ch_enable[grant] & credit_ok;
        fifo_rd_en = '0;
        fifo_rd_en[grant] = issue;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            grant     <= '0;
            rr_last   <= CH_W'(NUM_CH - 1);
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick_vld) begin
                grant     <= pick;
                burst_cnt <= '0;
            end
        end else begin
            if (issue) burst_cnt <= burst_cnt + 8'd1;
            if (burst_end) rr_last <= grant;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_pend <= 1'b0;
            pend_ch <= '0;
            count   <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
        end else begin
            rd_pend <= issue;
            pend_ch <= grant;
            if (rd_pend) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, rd_pend} - {1'b0, pop};
        end
    end

    always_ff @(posedge rclk) begin
        if (rd_pend) begin
            buf_data[wr_ptr] <= fifo_rdata[int'(pend_ch)*DATA_WIDTH +: DATA_WIDTH];
            buf_ch[wr_ptr]   <= pend_ch;
        end
    end

    assign out_valid = count != 2'd0;
    assign out_data  = out_valid ? buf_data[rd_ptr] : '0;
    assign out_ch    = out_valid ? buf_ch[rd_ptr] : '0;
    assign busy      = (state == BURST) | rd_pend | out_valid;
endmodule

// File: tb/tb_async_fifo_rd_arbiter.sv
// tb_async_fifo_rd_arbiter: FIFO models plus per-channel scoreboard and burst-order expectations for the read arbiter
module tb_async_fifo_rd_arbiter;
    localparam int NUM_CH = 4;
    localparam int DW     = 8;
    localparam int BM     = 4;
    localparam int DEPTH  = 64;

    logic rclk = 1'b0;
    logic rrst_n = 1'b0;
    logic [NUM_CH-1:0] ch_enable = '1;
    logic [NUM_CH-1:0] fifo_empty, fifo_rd_en;
    logic [NUM_CH*DW-1:0] fifo_rdata;
    logic [DW-1:0] out_data;
    logic [1:0] out_ch;
    logic out_valid, busy;
    logic out_ready = 1'b0;

    logic [DW-1:0] mem [NUM_CH][DEPTH];
    int wptr [NUM_CH];
    int rptr [NUM_CH];
    int sb_ptr [NUM_CH];
    int errors = 0;
    int checks = 0;
    int issued, taken;
    int rd_log[$];
    int out_cyc_log[$];
    int out_ch_log[$];
    logic [NUM_CH-1:0] emp_log[$];
    int b_ch[$];
    int b_len[$];
    int b_start[$];

    always #5 rclk = ~rclk;

    async_fifo_rd_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .ch_enable(ch_enable), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    // Read side of each FIFO: data one clock after rd_en, empty registered from the next pointer.
    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < NUM_CH; i++) rptr[i] <= 0;
            fifo_empty <= '1;
            fifo_rdata <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (fifo_rd_en[i] && rptr[i] < wptr[i]) begin
                    fifo_rdata[i*DW +: DW] <= mem[i][rptr[i]];
                    rptr[i] <= rptr[i] + 1;
                    fifo_empty[i] <= (wptr[i] == rptr[i] + 1);
                end else fifo_empty[i] <= (wptr[i] == rptr[i]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required self-termination");
        $fatal(1);
    end

    function automatic int enc(input logic [NUM_CH-1:0] v);
        int r;
        r = -1;
        for (int i = NUM_CH - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    function automatic int count_rd(input int ch);
        int n;
        n = 0;
        foreach (rd_log[k]) if (rd_log[k] == ch) n++;
        return n;
    endfunction

    function automatic void parse_bursts();
        b_ch.delete(); b_len.delete(); b_start.delete();
        foreach (rd_log[k]) if (rd_log[k] >= 0) begin
            if (k > 0 && rd_log[k-1] == rd_log[k]) b_len[b_len.size()-1] = b_len[b_len.size()-1] + 1;
            else begin
                b_ch.push_back(rd_log[k]); b_len.push_back(1); b_start.push_back(k);
            end
        end
    endfunction

    task automatic load(input int ch, input int n);
        for (int k = 0; k < n && wptr[ch] < DEPTH; k++) begin
            mem[ch][wptr[ch]] = DW'($urandom);
            wptr[ch]++;
        end
    endtask

    // One clock: observe the cycle at the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge rclk);
        if (rrst_n) begin
            rd_log.push_back(enc(fifo_rd_en));
            emp_log.push_back(fifo_empty);
            checks++;
            if (!$onehot0(fifo_rd_en) || (fifo_rd_en & (fifo_empty | ~ch_enable)) != '0) begin
                errors++;
                $display("FAIL rd_en_legal: rd_en=%b with empty=%b enable=%b, required onehot0 on non-empty enabled", fifo_rd_en, fifo_empty, ch_enable);
            end
            if (fifo_rd_en != '0) issued++;
            if (out_valid && out_ready) begin
                checks++;
                if (sb_ptr[out_ch] >= wptr[out_ch]) begin
                    errors++;
                    $display("FAIL out_word: ch%0d data %h, required no word (channel already drained)", out_ch, out_data);
                end else begin
                    if (out_data !== mem[out_ch][sb_ptr[out_ch]]) begin
                        errors++;
                        $display("FAIL out_word: ch%0d data %h, required %h", out_ch, out_data, mem[out_ch][sb_ptr[out_ch]]);
                    end
                    sb_ptr[out_ch]++;
                end
                taken++;
                out_cyc_log.push_back(rd_log.size() - 1);
                out_ch_log.push_back(int'(out_ch));
            end
            checks++;
            if (issued - taken > 2) begin
                errors++;
                $display("FAIL outstanding: %0d words issued but not delivered, required <= 2", issued - taken);
            end
        end
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            wptr[i] = 0; sb_ptr[i] = 0;
        end
        issued = 0; taken = 0;
        repeat (2) @(posedge rclk);
        #1 rrst_n = 1'b1;
        rd_log.delete(); emp_log.delete(); out_cyc_log.delete(); out_ch_log.delete();
    endtask

    // mode 0: always ready, 1: ready 1,0,0 repeating, 2: random ready
    task automatic run_until(input int n, input int mode, input string name);
        for (int k = 0; k < 600 && taken < n; k++) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : ($urandom_range(0, 3) != 0);
            tick();
        end
        checks++;
        if (taken != n) begin
            errors++;
            $display("FAIL %s_drain: words out %0d, required %0d", name, taken, n);
        end
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        repeat (2) @(posedge rclk);
        #1;
        checks++; if (fifo_rd_en !== '0) begin errors++; $display("FAIL reset_rd_en: %b, required 0", fifo_rd_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: %b, required 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: %h, required 0", out_data); end
        checks++; if (out_ch !== '0) begin errors++; $display("FAIL reset_out_ch: %0d, required 0", out_ch); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b, required 0", busy); end
    endtask

    task automatic test_single_channel();
        int e, f, n;
        do_reset();
        ch_enable = '1;
        load(0, 3);
        run_until(3, 0, "single");
        repeat (2) tick();
        e = -1; f = -1;
        foreach (emp_log[k]) if (e < 0 && !emp_log[k][0]) e = k;
        foreach (rd_log[k]) if (f < 0 && rd_log[k] == 0) f = k;
        n = count_rd(0);
        checks++;
        if (e < 0 || f != e + 1) begin errors++; $display("FAIL single_rd_latency: first rd_en cycle %0d, required %0d", f, e + 1); end
        checks++;
        if (n != 3 || f < 0 || f + 2 >= rd_log.size() || rd_log[f+1] != 0 || rd_log[f+2] != 0) begin
            errors++; $display("FAIL single_rd_burst: %0d reads from cycle %0d, required 3 consecutive", n, f);
        end
        checks++;
        if (out_cyc_log.size() != 3 || out_cyc_log[0] != f + 2 || out_cyc_log[1] != f + 3 || out_cyc_log[2] != f + 4) begin
            errors++; $display("FAIL single_out_timing: first word at cycle %0d, required cycles %0d..%0d",
                               out_cyc_log.size() > 0 ? out_cyc_log[0] : -1, f + 2, f + 4);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b out_valid=%b, required 0 0", busy, out_valid); end
    endtask

    task automatic test_round_robin();
        int gap;
        do_reset();
        ch_enable = '1;
        for (int c = 0; c < NUM_CH; c++) load(c, 8);
        run_until(32, 0, "rr");
        parse_bursts();
        checks++;
        if (b_ch.size() != 8) begin errors++; $display("FAIL rr_bursts: %0d bursts, required 8", b_ch.size()); end
        for (int k = 0; k < b_ch.size() && k < 8; k++) begin
            checks++;
            if (b_ch[k] != k % NUM_CH || b_len[k] != BM) begin
                errors++; $display("FAIL rr_burst%0d: ch%0d len %0d, required ch%0d len %0d", k, b_ch[k], b_len[k], k % NUM_CH, BM);
            end
            if (k > 0) begin
                gap = b_start[k] - b_start[k-1] - b_len[k-1];
                checks++;
                if (gap != 1) begin errors++; $display("FAIL rr_gap%0d: %0d idle cycles, required 1", k, gap); end
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (sb_ptr[c] != 8) begin errors++; $display("FAIL rr_words_ch%0d: %0d delivered, required 8", c, sb_ptr[c]); end
        end
    endtask

    task automatic test_credit_stall();
        int seq[$];
        int exp_seq[8] = '{1, 1, 1, 1, 2, 2, 1, 1};
        do_reset();
        ch_enable = '1;
        load(1, 6);
        load(2, 2);
        run_until(8, 1, "stall");
        foreach (rd_log[k]) if (rd_log[k] >= 0) seq.push_back(rd_log[k]);
        checks++;
        if (seq.size() != 8) begin errors++; $display("FAIL stall_reads: %0d reads, required 8", seq.size()); end
        for (int k = 0; k < seq.size() && k < 8; k++) begin
            checks++;
            if (seq[k] != exp_seq[k]) begin errors++; $display("FAIL stall_order%0d: ch%0d, required ch%0d", k, seq[k], exp_seq[k]); end
        end
    endtask

    task automatic test_enable_mask();
        int exp_ch[6] = '{0, 1, 3, 0, 1, 3};
        do_reset();
        ch_enable = 4'b1011;
        for (int c = 0; c < NUM_CH; c++) load(c, 8);
        run_until(24, 0, "mask");
        parse_bursts();
        checks++;
        if (b_ch.size() != 6) begin errors++; $display("FAIL mask_bursts: %0d bursts, required 6", b_ch.size()); end
        for (int k = 0; k < b_ch.size() && k < 6; k++) begin
            checks++;
            if (b_ch[k] != exp_ch[k] || b_len[k] != BM) begin
                errors++; $display("FAIL mask_burst%0d: ch%0d len %0d, required ch%0d len %0d", k, b_ch[k], b_len[k], exp_ch[k], BM);
            end
        end
        checks++;
        if (count_rd(2) != 0 || sb_ptr[2] != 0) begin errors++; $display("FAIL mask_ch2: %0d reads, required 0", count_rd(2)); end
    endtask

    task automatic test_enable_drop();
        int exp_ch[4] = '{0, 0, 1, 1};
        do_reset();
        ch_enable = '1;
        load(0, 4);
        load(1, 2);
        out_ready = 1'b1;
        for (int k = 0; k < 30 && count_rd(0) < 2; k++) tick();
        ch_enable[0] = 1'b0;
        run_until(4, 0, "drop");
        parse_bursts();
        checks++;
        if (count_rd(0) != 2) begin errors++; $display("FAIL drop_ch0_reads: %0d, required 2", count_rd(0)); end
        checks++;
        if (b_ch.size() < 2 || b_ch[1] != 1) begin errors++; $display("FAIL drop_next_grant: %0d bursts, required second burst on ch1", b_ch.size()); end
        for (int k = 0; k < out_ch_log.size() && k < 4; k++) begin
            checks++;
            if (out_ch_log[k] != exp_ch[k]) begin errors++; $display("FAIL drop_out%0d: ch%0d, required ch%0d", k, out_ch_log[k], exp_ch[k]); end
        end
        ch_enable = '1;
    endtask

    task automatic test_reset_midburst();
        int f;
        do_reset();
        ch_enable = '1;
        load(0, 1);
        load(1, 8);
        out_ready = 1'b0;
        repeat (10) tick();
        checks++;
        if (issued - taken != 2 || out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_buffered: %0d words held, out_valid=%b, required 2 and 1", issued - taken, out_valid);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 4'b0010) begin errors++; $display("FAIL mid_rd_en: %b, required 0010", fifo_rd_en); end
        #1 rrst_n = 1'b0;
        #1;
        checks++;
        if (fifo_rd_en !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_async_reset: rd_en=%b out_valid=%b busy=%b, required all 0", fifo_rd_en, out_valid, busy);
        end
        do_reset();
        load(0, 3);
        load(1, 3);
        run_until(6, 0, "post_reset");
        f = -1;
        foreach (rd_log[k]) if (f < 0 && rd_log[k] >= 0) f = rd_log[k];
        checks++;
        if (f != 0) begin errors++; $display("FAIL post_reset_grant: first read ch%0d, required ch0", f); end
    endtask

    task automatic test_random();
        int total;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            ch_enable = NUM_CH'($urandom);
            total = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                load(c, $urandom_range(0, 12));
                if (ch_enable[c]) total += wptr[c];
            end
            run_until(total, 2, "random");
            out_ready = 1'b1;
            repeat (4) tick();
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL random_busy: %b after drain, required 0", busy); end
            for (int c = 0; c < NUM_CH; c++) begin
                checks++;
                if (sb_ptr[c] != (ch_enable[c] ? wptr[c] : 0)) begin
                    errors++; $display("FAIL random_ch%0d: %0d delivered, required %0d", c, sb_ptr[c], ch_enable[c] ? wptr[c] : 0);
                end
            end
        end
        ch_enable = '1;
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_credit_stall();
        test_enable_mask();
        test_enable_drop();
        test_reset_midburst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/async_fifo_rd_arbiter.md
Name: async_fifo_rd_arbiter

Overview:
- Read-side scheduler in the rclk domain. It drains the read ports of NUM_CH async FIFOs onto one valid/ready output stream.
- Grants one FIFO at a time, round-robin, with bursts of up to BURST_MAX words. Drives each FIFO's rd_en from that FIFO's registered empty flag.
- Tags each output word with its source channel. A 2-entry output buffer with credit-gated issue gives full throughput under backpressure.

Parameters:
NUM_CH, 4, number of FIFO read ports arbitrated (2..16)
DATA_WIDTH, 8, FIFO word width
BURST_MAX, 4, maximum reads issued per grant (1..255)
CH_W, max(1,$clog2(NUM_CH)), channel index width (derived localparam)

Ports:
rclk  in  1  read-domain clock
rrst_n  in  1  reset, asynchronous, active-low
ch_enable  in  NUM_CH  per-channel enable; a disabled channel is never granted
fifo_empty  in  NUM_CH  registered empty flag from each FIFO read side
fifo_rdata  in  NUM_CH*DATA_WIDTH  FIFO read data; channel i is at [i*DATA_WIDTH +: DATA_WIDTH], valid one rclk after rd_en
fifo_rd_en  out  NUM_CH  per-FIFO read strobe, at most one bit high (one-hot or zero)
out_data  out  DATA_WIDTH  head word of the output buffer
out_ch  out  CH_W  source channel of out_data
out_valid  out  1  output buffer non-empty
out_ready  in  1  downstream accept; a transfer happens when out_valid & out_ready
busy  out  1  high in BURST state or while reads are in flight or buffered

Behaviour:
- Reset (async, rrst_n=0):
  - state=IDLE, rr_last=NUM_CH-1, grant=0, burst_cnt=0, rd_pend=0, buffer count=0.
  - fifo_rd_en=0, out_valid=0, out_data=0, out_ch=0, busy=0.
- States: IDLE, BURST.
- IDLE:
  - Candidate set = ch_enable & ~fifo_empty.
  - If non-empty: pick the first candidate searching from rr_last+1 upward with wrap modulo NUM_CH. Register it as grant, clear burst_cnt, go to BURST.
  - If empty: stay in IDLE.
  - No rd_en is asserted in IDLE.
- BURST:
  - issue = ~fifo_empty[grant] & ch_enable[grant] & credit_ok.
  - fifo_rd_en[grant] = issue; all other bits are 0.
  - burst_cnt increments on issue.
  - Go to IDLE and set rr_last=grant when any of these holds:
    - issue & burst_cnt==BURST_MAX-1;
    - fifo_empty[grant]=1;
    - ch_enable[grant]=0.
  - Stalling on credit alone keeps the grant; the burst does not end.
- Grant-switch cost: one IDLE cycle between bursts, so arbitration is not pipelined.
- Latency:
  - A FIFO going non-empty in IDLE gets its first rd_en 1 cycle later.
  - Its data enters the buffer at the clock after rd_en.
  - out_valid rises at the clock edge 2 cycles after the rd_en cycle starts.
- Read pipeline:
  - rd_pend <= issue; pend_ch <= grant.
  - When rd_pend=1, fifo_rdata[pend_ch] and pend_ch are pushed into the output buffer at that clock edge.
- Output buffer: 2-entry FIFO, first-word-fall-through.
  - out_valid = (count!=0); out_data/out_ch show the head entry.
  - Push and pop in the same cycle is allowed; count is unchanged.
- Credit: credit_ok = (count + rd_pend - (out_valid & out_ready)) < 2.
  - Combinational path from out_ready to fifo_rd_en is accepted.
  - Guarantees no overflow and a sustained 1 word/cycle when out_ready=1.
- Ordering: output order equals issue order. No word is dropped or duplicated.
- Reliance on FIFO: the FIFO's empty is registered from its next pointer, so it is accurate in the cycle after a read. Back-to-back rd_en on the last word is therefore safe, because empty is 1 on the following cycle.
- A ch_enable drop mid-burst blocks issue in that same cycle. Reads already issued still complete into the buffer.
- Reset mid-operation: everything is cleared asynchronously and buffered or in-flight words are discarded. The FIFOs share rrst_n, so pointers stay consistent.
- busy = (state==BURST) | rd_pend | (count!=0).

Test Plan:
- Ch0 holds 3 words (A,B,C), others empty, out_ready=1, BURST_MAX=4:
  - rd_en[0] asserted for 3 consecutive cycles;
  - out sequence A,B,C with out_ch=0 on consecutive cycles;
  - state returns to IDLE after empty rises.
- All 4 channels hold 8 words, BURST_MAX=4, out_ready=1:
  - grants in order 0,1,2,3,0,... with exactly 4 reads each;
  - one idle cycle between bursts;
  - 32 words out, in per-channel order.
- Ch1 holds 6 words, out_ready toggles 1,0,0,1,...:
  - count never exceeds 2 and no words are lost or duplicated;
  - rd_en is deasserted whenever credit_ok=0;
  - grant is held across stalls.
- ch_enable=4'b1011, all channels full:
  - ch2 is never granted and rd_en[2] stays 0;
  - rotation is 0,1,3,0.
- Ch0 is granted and ch_enable[0] drops after 2 reads:
  - those 2 words are still output;
  - next grant goes to the next non-empty enabled channel.
- rrst_n pulsed low mid-burst with 2 words buffered:
  - out_valid and fifo_rd_en drop immediately (async);
  - after release, first grant goes to ch0 if it is non-empty.
